regfile_read_arbiter: RTL and testbench

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

---
 rtl/regfile_arb_pkg.sv | 21 ++
 rtl/regfile_read_arbiter_rr_pick.sv | 47 ++++
 rtl/regfile_read_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_read_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared definitions for the register-file read arbiter:
//               FSM state encoding and default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_read_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches req upward from
//               i_ptr, wrapping modulo NREQ, and returns the first set bit.
// Ports       : i_req    - request vector
//               i_ptr    - search start index (always < NREQ)
//               o_winner - one-hot winner (all zero when no request)
//               o_idx    - binary index of the winner
//               o_any    - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [NREQ-1:0] o_winner,
    output logic [1:0]      o_idx,
    output logic            o_any
);

    int w_j;

    always_comb begin
        o_winner = '0;
        o_idx    = 2'd0;
        o_any    = 1'b0;
        w_j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Rotated position; i_ptr < NREQ so one subtraction wraps it.
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!o_any && i_req[w_j]) begin
                o_any       = 1'b1;
                o_idx       = 2'(w_j);
                o_winner[w_j] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Round-robin arbiter sharing one register-file read port
//               (external 32:1 mux) among NREQ requesters. Two-state FSM:
//               IDLE picks a winner and drives sel, READ captures mux_y.
//               One read per two cycles.
// Ports       : clk, rst_n (synchronous, active-low)
//               req[NREQ]      - level requests
//               addr[NREQ*AW]  - flattened addresses, slice i for req[i]
//               sel[AW]        - select to external read mux
//               mux_y[DW]      - external read mux output
//               gnt[NREQ]      - one-hot grant pulse
//               rvalid, rdata[DW], rid[2] - read response
// Config      : REGFILE_ARB_ZERO_FORCE_EN - reads of register 0 return 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [AW-1:0]     sel,
    input  logic [DW-1:0]     mux_y,
    output logic [NREQ-1:0]   gnt,
    output logic              rvalid,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        rid
);

    localparam logic [1:0] c_last = 2'(NREQ - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_ptr;
    logic [1:0]        r_owner;
    logic [AW-1:0]     r_sel;
    logic [NREQ-1:0]   r_gnt;
    logic              r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic [1:0]        r_rid;

    logic [NREQ-1:0]   w_winner;
    logic [1:0]        w_idx;
    logic              w_any;
    logic [DW-1:0]     w_rdata_cap;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // Value captured into rdata during READ.
`ifdef REGFILE_ARB_ZERO_FORCE_EN
    assign w_rdata_cap = (r_sel == '0) ? '0 : mux_y;
`else
    assign w_rdata_cap = mux_y;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = READ;
            READ:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Grant/select latch and read capture. gnt and rvalid are single-cycle
    // pulses, so they default low every cycle. sel is only written on a
    // grant, which keeps it stable through the capture edge and idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr    <= 2'd0;
            r_owner  <= 2'd0;
            r_sel    <= '0;
            r_gnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= 2'd0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    r_sel   <= addr[AW*int'(w_idx) +: AW];
                    r_owner <= w_idx;
                    r_gnt   <= w_winner;
                end
            end else begin
                r_rdata  <= w_rdata_cap;
                r_rid    <= r_owner;
                r_rvalid <= 1'b1;
                // Next search starts just past the requester just served.
                r_ptr    <= (r_owner == c_last) ? 2'd0 : r_owner + 2'd1;
            end
        end
    end

    assign sel    = r_sel;
    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rid    = r_rid;

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
// ============================================================================
// Module      : tb_regfile_read_arbiter
// Description : Self-checking bench for regfile_read_arbiter. Expected read
//               responses are queued when a grant is observed and compared
//               when rvalid pulses. External mux model: mux_y = 0x100 + sel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_read_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [AW-1:0]       a [NREQ];
    logic [NREQ*AW-1:0]  addr;
    logic [AW-1:0]       sel;
    logic [DW-1:0]       mux_y;
    logic [NREQ-1:0]     gnt;
    logic                rvalid;
    logic [DW-1:0]       rdata;
    logic [1:0]          rid;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    assign addr  = {a[2], a[1], a[0]};
    assign mux_y = 32'h100 + 32'(sel);

    regfile_read_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .addr   (addr),
        .sel    (sel),
        .mux_y  (mux_y),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rid    (rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_data(input logic [AW-1:0] ad);
`ifdef REGFILE_ARB_ZERO_FORCE_EN
        if (ad == '0) return 32'h0;
`endif
        return 32'h100 + 32'(ad);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a grant appears (bounded), check it against the
    // expected requester, queue its read response, and optionally drop req.
    task automatic wait_grant(input int idx, input bit hold, input bit scored, output int at);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 8);
        at = cyc;
        if (gnt == '0) begin
            check($sformatf("gnt%0d_timeout", idx), 64'(n), 64'd0);
        end else begin
            check($sformatf("gnt%0d", idx), 64'(gnt), 64'(1 << idx));
            if (scored) sb.push_back('{2'(idx), exp_data(a[idx])});
        end
        if (!hold) req[idx] = 1'b0;
    endtask

    // Response monitor and grant-shape checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 64'(rvalid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", 64'(rdata), 64'(e.data));
                check("rid", 64'(rid), 64'(e.id));
            end
        end
        if (gnt != '0) begin
            check("gnt_onehot", 64'($countones(gnt)), 64'd1);
            check("gnt_rvalid_excl", 64'(rvalid), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, dummy;
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) a[i] = '0;
        repeat (2) tick();

        check("rst_gnt",    64'(gnt),    64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata",  64'(rdata),  64'd0);
        check("rst_rid",    64'(rid),    64'd0);
        check("rst_sel",    64'(sel),    64'd0);

        // Contention from ptr=0 on the very first edge out of reset.
        rst_n = 1'b1;
        a[0] = 5'd3; a[1] = 5'd5; a[2] = 5'd11;
        req  = 3'b111;
        wait_grant(0, 1'b0, 1'b1, c0);
        wait_grant(1, 1'b0, 1'b1, c1);
        wait_grant(2, 1'b0, 1'b1, c2);
        check("cont_spacing01", 64'(c1 - c0), 64'd2);
        check("cont_spacing12", 64'(c2 - c1), 64'd2);
        repeat (3) tick();

        // Fairness: requesters 0 and 2 keep re-requesting.
        a[0] = 5'd4; a[2] = 5'd20;
        req  = 3'b101;
        wait_grant(0, 1'b1, 1'b1, dummy);
        wait_grant(2, 1'b1, 1'b1, dummy);
        wait_grant(0, 1'b1, 1'b1, dummy);
        wait_grant(2, 1'b1, 1'b1, dummy);
        req = '0;
        repeat (3) tick();

        // Register zero.
        a[0] = 5'd0;
        req  = 3'b001;
        wait_grant(0, 1'b0, 1'b1, dummy);
        repeat (3) tick();

        // Single request with latency checks.
        a[1] = 5'd7;
        req  = 3'b010;
        wait_grant(1, 1'b0, 1'b1, dummy);
        tick();
        check("single_rvalid", 64'(rvalid), 64'd1);
        check("single_rdata",  64'(rdata),  64'h107);
        tick();
        check("rvalid_pulse",  64'(rvalid), 64'd0);

        // Withdrawal: req1 raised and dropped between edges.
        req = 3'b010;
        #3;
        req = 3'b000;
        repeat (3) begin
            tick();
            check("wd_gnt",    64'(gnt),    64'd0);
            check("wd_rvalid", 64'(rvalid), 64'd0);
        end
        check("wd_sel", 64'(sel), 64'd7);

        // ptr was left at 2 by the last served read (owner 1).
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd30;
        req  = 3'b111;
        wait_grant(2, 1'b0, 1'b1, dummy);
        req = '0;
        repeat (3) tick();

        // Reset on the capture edge aborts the read.
        a[1] = 5'd9;
        req  = 3'b010;
        wait_grant(1, 1'b0, 1'b0, dummy);
        rst_n = 1'b0;
        tick();
        check("rr_rvalid", 64'(rvalid), 64'd0);
        check("rr_gnt",    64'(gnt),    64'd0);
        check("rr_rdata",  64'(rdata),  64'd0);
        check("rr_rid",    64'(rid),    64'd0);
        check("rr_sel",    64'(sel),    64'd0);
        rst_n = 1'b1;
        a[2] = 5'd13;
        req  = 3'b100;
        wait_grant(2, 1'b0, 1'b1, dummy);
        repeat (3) tick();

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
